// File: rtl/mem_access_ctrl.sv
// Multi-cycle load/store sequencer in front of a byte-wide synchronous memory; words go as two bytes.
// Define MEMCTRL_BIG_ENDIAN_EN to place the high byte of a word at the lower address.
module mem_access_ctrl #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                reqValid,
  output logic                reqReady,
  input  logic                reqWrite,
  input  logic                reqWord,
  input  logic [ADDR_W-1:0]   reqAddr,
  input  logic [2*DATA_W-1:0] reqWData,
  output logic                rspValid,
  output logic [2*DATA_W-1:0] rspRData,
  output logic [ADDR_W-1:0]   memAddress,
  output logic [DATA_W-1:0]   memInData,
  output logic                memReadEn,
  output logic                memWriteEn,
  input  logic [DATA_W-1:0]   memOutData
);

  typedef enum logic [2:0] {StIdle, StWlo, StWhi, StRlo, StRhi, StRlast, StResp} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2*DATA_W-1:0] wdata_q, wdata_d;
  logic [2*DATA_W-1:0] rdata_q, rdata_d;
  logic                word_q, word_d;
  logic [ADDR_W-1:0]   maddr_q, maddr_d;
  logic [DATA_W-1:0]   mdin_q, mdin_d;
  logic                rd_en_q, rd_en_d;
  logic                wr_en_q, wr_en_d;
  logic                rsp_q, rsp_d;
  logic [DATA_W-1:0]   first_byte, second_byte;

  // Direction is carried by the state itself (Wxx vs Rxx), so reqWrite needs no latch.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (reqValid) begin
          addr_d  = reqAddr;
          wdata_d = reqWData;
          word_d  = reqWord;
          state_d = reqWrite ? StWlo : StRlo;
        end
      end
      StWlo: state_d = word_q ? StWhi : StResp;
      StWhi: state_d = StResp;
      StRlo: state_d = word_q ? StRhi : StRlast;
      StRhi: begin
`ifdef MEMCTRL_BIG_ENDIAN_EN
        rdata_d[2*DATA_W-1:DATA_W] = memOutData;
`else
        rdata_d[DATA_W-1:0] = memOutData;
`endif
        state_d = StRlast;
      end
      StRlast: begin
        if (word_q) begin
`ifdef MEMCTRL_BIG_ENDIAN_EN
          rdata_d[DATA_W-1:0] = memOutData;
`else
          rdata_d[2*DATA_W-1:DATA_W] = memOutData;
`endif
        end else begin
          rdata_d = {{DATA_W{1'b0}}, memOutData};
        end
        state_d = StResp;
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Byte accesses always use the low half regardless of byte order.
`ifdef MEMCTRL_BIG_ENDIAN_EN
  assign first_byte  = word_d ? wdata_d[2*DATA_W-1:DATA_W] : wdata_d[DATA_W-1:0];
  assign second_byte = wdata_d[DATA_W-1:0];
`else
  assign first_byte  = wdata_d[DATA_W-1:0];
  assign second_byte = wdata_d[2*DATA_W-1:DATA_W];
`endif

  // Memory-side outputs are registered from the next state, so they never see req* combinationally.
  always_comb begin
    rd_en_d = 1'b0;
    wr_en_d = 1'b0;
    rsp_d   = 1'b0;
    maddr_d = addr_d;
    mdin_d  = '0;
    unique case (state_d)
      StWlo: begin
        wr_en_d = 1'b1;
        mdin_d  = first_byte;
      end
      StWhi: begin
        wr_en_d = 1'b1;
        maddr_d = addr_d + ADDR_W'(1);
        mdin_d  = second_byte;
      end
      StRlo: rd_en_d = 1'b1;
      StRhi: begin
        rd_en_d = 1'b1;
        maddr_d = addr_d + ADDR_W'(1);
      end
      StResp: rsp_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= 1'b0;
      rdata_q <= '0;
      maddr_q <= '0;
      mdin_q  <= '0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      rsp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
      maddr_q <= maddr_d;
      mdin_q  <= mdin_d;
      rd_en_q <= rd_en_d;
      wr_en_q <= wr_en_d;
      rsp_q   <= rsp_d;
    end
  end

  assign reqReady   = (state_q == StIdle);
  assign rspValid   = rsp_q;
  assign rspRData   = rdata_q;
  assign memAddress = maddr_q;
  assign memInData  = mdin_q;
  assign memReadEn  = rd_en_q;
  assign memWriteEn = wr_en_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: byte-level reference model checked every cycle plus directed literals.
// Honours MEMCTRL_BIG_ENDIAN_EN the same way as the design.
module tb_mem_access_ctrl;

  logic        clk, rst;
  logic        reqValid, reqReady, reqWrite, reqWord;
  logic [12:0] reqAddr;
  logic [15:0] reqWData;
  logic        rspValid;
  logic [15:0] rspRData;
  logic [12:0] memAddress;
  logic [7:0]  memInData;
  logic        memReadEn, memWriteEn;
  logic [7:0]  memOutData;

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  mem_access_ctrl #(.ADDR_W(13), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite), .reqWord(reqWord),
    .reqAddr(reqAddr), .reqWData(reqWData),
    .rspValid(rspValid), .rspRData(rspRData),
    .memAddress(memAddress), .memInData(memInData),
    .memReadEn(memReadEn), .memWriteEn(memWriteEn), .memOutData(memOutData)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Synchronous memory seen by the DUT: read data appears the cycle after the read enable.
  logic [7:0] env_mem [0:8191];
  always @(posedge clk) begin
    if (memWriteEn) env_mem[memAddress] <= memInData;
    if (memReadEn) memOutData <= env_mem[memAddress];
  end

  // Reference model: what a request must do, cycle by cycle, after its acceptance.
  logic [7:0]  ref_mem [0:8191];
  logic        m_busy, m_write, m_word;
  int unsigned m_ofs;
  logic [12:0] m_a;
  logic [15:0] m_wd, m_hold;

  function automatic int unsigned nbytes(input logic word);
    return word ? 2 : 1;
  endfunction

  function automatic int unsigned req_len(input logic write, input logic word);
    return write ? nbytes(word) + 1 : nbytes(word) + 2;
  endfunction

  function automatic logic [7:0] store_byte(input logic [15:0] d, input logic word,
                                            input int unsigned k);
    if (!word) return d[7:0];
`ifdef MEMCTRL_BIG_ENDIAN_EN
    return (k == 1) ? d[15:8] : d[7:0];
`else
    return (k == 1) ? d[7:0] : d[15:8];
`endif
  endfunction

  function automatic logic [15:0] load_val(input logic [12:0] a, input logic word);
    logic [12:0] a1;
    a1 = a + 13'd1;
    if (!word) return {8'h00, ref_mem[a]};
`ifdef MEMCTRL_BIG_ENDIAN_EN
    return {ref_mem[a], ref_mem[a1]};
`else
    return {ref_mem[a1], ref_mem[a]};
`endif
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy  <= 1'b0;
      m_ofs   <= 0;
      m_a     <= '0;
      m_wd    <= '0;
      m_write <= 1'b0;
      m_word  <= 1'b0;
      m_hold  <= '0;
    end else if (m_busy) begin
      if (m_write && m_ofs <= nbytes(m_word))
        ref_mem[m_a + 13'(m_ofs - 1)] <= store_byte(m_wd, m_word, m_ofs);
      if (!m_write && m_ofs == nbytes(m_word) + 2) m_hold <= load_val(m_a, m_word);
      if (m_ofs == req_len(m_write, m_word)) m_busy <= 1'b0;
      else m_ofs <= m_ofs + 1;
    end else if (reqValid) begin
      m_busy  <= 1'b1;
      m_ofs   <= 1;
      m_a     <= reqAddr;
      m_wd    <= reqWData;
      m_write <= reqWrite;
      m_word  <= reqWord;
    end
  end

  logic        e_rdy, e_re, e_we, e_rv, e_chk_rd;
  logic [12:0] e_addr;
  logic [7:0]  e_din;
  logic [15:0] e_rd;

  always @(negedge clk) begin
    e_rdy = !m_busy; e_re = 1'b0; e_we = 1'b0; e_rv = 1'b0;
    e_addr = m_a; e_din = 8'h00; e_chk_rd = 1'b1; e_rd = m_hold;
    if (m_busy) begin
      if (m_write) begin
        if (m_ofs <= nbytes(m_word)) begin
          e_we = 1'b1;
          e_addr = m_a + 13'(m_ofs - 1);
          e_din = store_byte(m_wd, m_word, m_ofs);
        end else e_rv = 1'b1;
      end else begin
        if (m_ofs <= nbytes(m_word)) begin
          e_re = 1'b1;
          e_addr = m_a + 13'(m_ofs - 1);
        end
        if (m_ofs == nbytes(m_word) + 2) begin
          e_rv = 1'b1;
          e_rd = load_val(m_a, m_word);
        end else e_chk_rd = 1'b0;
      end
    end
    chk("reqReady", reqReady, e_rdy);
    chk("memReadEn", memReadEn, e_re);
    chk("memWriteEn", memWriteEn, e_we);
    chk("rspValid", rspValid, e_rv);
    chk("memAddress", memAddress, e_addr);
    chk("memInData", memInData, e_din);
    chk("rd_wr_exclusive", memReadEn & memWriteEn, 0);
    if (e_chk_rd) chk("rspRData", rspRData, e_rd);
  end

  // Presents a request and returns just after its acceptance edge (early in cycle 1).
  task automatic issue(input logic w, input logic wd, input logic [12:0] a,
                       input logic [15:0] d, input logic keep);
    logic got;
    reqWrite = w; reqWord = wd; reqAddr = a; reqWData = d; reqValid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (reqReady) got = 1'b1;
    end
    if (!got) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (!keep) reqValid = 1'b0;
  endtask

  // Counts negedges from cycle 1 until rspValid; leaves time just after the following edge.
  task automatic wait_rsp(output int lat, output logic [15:0] rd, input logic realign);
    lat = -1;
    rd = 'x;
    for (int k = 1; k <= 12 && lat < 0; k++) begin
      @(negedge clk);
      if (rspValid) begin
        lat = k;
        rd = rspRData;
      end
    end
    if (lat < 0) chk("rsp_timeout", 0, 1);
    if (realign) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic xact(input string name, input logic w, input logic wd, input logic [12:0] a,
                      input logic [15:0] d, input int exp_lat, input logic [15:0] exp_rd);
    int lat;
    logic [15:0] rd;
    issue(w, wd, a, d, 1'b0);
    wait_rsp(lat, rd, 1'b1);
    chk({name, "_latency"}, lat, exp_lat);
    if (!w) chk({name, "_rdata"}, rd, exp_rd);
  endtask

  int          lat;
  logic [15:0] rd;

  initial begin
    for (int i = 0; i < 8192; i++) begin
      env_mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    rst = 1'b0; reqValid = 1'b0; reqWrite = 1'b0; reqWord = 1'b0;
    reqAddr = '0; reqWData = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    chk("reset_ready", reqReady, 1);
    chk("reset_rdata", rspRData, 16'h0000);

    // Byte store then byte load at 0x0010.
    issue(1'b1, 1'b0, 13'h0010, 16'h00A5, 1'b0);
    #3;
    chk("wlo_we", memWriteEn, 1);
    chk("wlo_din", memInData, 8'hA5);
    wait_rsp(lat, rd, 1'b1);
    chk("bstore_latency", lat, 2);
    chk("bstore_mem", env_mem[13'h0010], 8'hA5);
    xact("bload", 1'b0, 1'b0, 13'h0010, 16'hFFFF, 3, 16'h00A5);

    // Word store/load at 0x0100.
    xact("wstore", 1'b1, 1'b1, 13'h0100, 16'hBEEF, 3, 16'h0000);
`ifdef MEMCTRL_BIG_ENDIAN_EN
    chk("wstore_lo", env_mem[13'h0100], 8'hBE);
    chk("wstore_hi", env_mem[13'h0101], 8'hEF);
    xact("bload_word_lo", 1'b0, 1'b0, 13'h0100, 16'h0000, 3, 16'h00BE);
`else
    chk("wstore_lo", env_mem[13'h0100], 8'hEF);
    chk("wstore_hi", env_mem[13'h0101], 8'hBE);
    xact("bload_word_lo", 1'b0, 1'b0, 13'h0100, 16'h0000, 3, 16'h00EF);
`endif
    xact("wload", 1'b0, 1'b1, 13'h0100, 16'h0000, 4, 16'hBEEF);

    // Word access wrapping from 0x1FFF to 0x0000.
    xact("wrap_store", 1'b1, 1'b1, 13'h1FFF, 16'h1234, 3, 16'h0000);
`ifdef MEMCTRL_BIG_ENDIAN_EN
    chk("wrap_mem_1fff", env_mem[13'h1FFF], 8'h12);
    chk("wrap_mem_0000", env_mem[13'h0000], 8'h34);
`else
    chk("wrap_mem_1fff", env_mem[13'h1FFF], 8'h34);
    chk("wrap_mem_0000", env_mem[13'h0000], 8'h12);
`endif
    xact("wrap_load", 1'b0, 1'b1, 13'h1FFF, 16'h0000, 4, 16'h1234);

    // reqValid held high: second request is taken only in the IDLE cycle after RESP.
    issue(1'b1, 1'b1, 13'h0300, 16'h5566, 1'b1);
    reqWrite = 1'b0; reqAddr = 13'h0300; reqWData = 16'h0000;
    wait_rsp(lat, rd, 1'b0);
    chk("held_store_latency", lat, 3);
    @(negedge clk);
    chk("held_ready_after_resp", reqReady, 1);
    @(posedge clk);
    #1 reqValid = 1'b0;
    wait_rsp(lat, rd, 1'b1);
    chk("held_load_latency", lat, 4);
    chk("held_load_rdata", rd, 16'h5566);

    // Reset during WHI of a word store abandons the second byte and the response.
    issue(1'b1, 1'b1, 13'h0200, 16'hCAFE, 1'b0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_we_drop", memWriteEn, 0);
    chk("rst_no_rsp", rspValid, 0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("ready_after_rst", reqReady, 1);
    repeat (4) @(negedge clk);
    chk("rst_mem_0201", env_mem[13'h0201], 8'h00);
`ifdef MEMCTRL_BIG_ENDIAN_EN
    chk("rst_mem_0200", env_mem[13'h0200], 8'hCA);
`else
    chk("rst_mem_0200", env_mem[13'h0200], 8'hFE);
`endif
    @(posedge clk);
    #1;

    // Byte load of 0xFF zero-extends and survives a later store.
    xact("ff_store", 1'b1, 1'b0, 13'h0400, 16'h12FF, 2, 16'h0000);
    xact("ff_load", 1'b0, 1'b0, 13'h0400, 16'h0000, 3, 16'h00FF);
    xact("ff_store2", 1'b1, 1'b1, 13'h0401, 16'h7788, 3, 16'h0000);
    chk("rdata_held_after_store", rspRData, 16'h00FF);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
